// File: rtl/ysyx_25030093_axil_sram.sv
// AXI4-Lite slave memory: independent read/write FSMs, programmable latency, byte strobes.
module ysyx_25030093_axil_sram #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter int unsigned       RD_LAT     = 1,
  parameter int unsigned       WR_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   SRAM_araddr,
  input  logic                SRAM_arvalid,
  output logic                SRAM_arready,
  output logic [DATA_W-1:0]   SRAM_rdata,
  output logic [1:0]          SRAM_rresp,
  output logic                SRAM_rvalid,
  input  logic                SRAM_rready,
  input  logic [ADDR_W-1:0]   SRAM_awaddr,
  input  logic                SRAM_awvalid,
  output logic                SRAM_awready,
  input  logic [DATA_W-1:0]   SRAM_wdata,
  input  logic [DATA_W/8-1:0] SRAM_wstrb,
  input  logic                SRAM_wvalid,
  output logic                SRAM_wready,
  output logic [1:0]          SRAM_bresp,
  output logic                SRAM_bvalid,
  input  logic                SRAM_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

  r_state_e            r_rstate;
  w_state_e            r_wstate;
  logic [ADDR_W-1:0]   r_raddr, r_waddr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [31:0]         r_rcnt, r_wcnt;
  logic                r_arready, r_rvalid, r_awready, r_wready, r_bvalid;
  logic [1:0]          r_rresp, r_bresp;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + LSB)) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] f_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return DEPTH_LOG2'(off >> LSB);
  endfunction

  // Read side: with RD_LAT=1 the sample uses the address on the bus at the AR handshake
  logic              w_ar_hs, w_rsample;
  logic [ADDR_W-1:0] w_rs_addr;
  assign w_ar_hs   = SRAM_arvalid & r_arready;
  assign w_rs_addr = (r_rstate == RIdle) ? SRAM_araddr : r_raddr;
  assign w_rsample = ((r_rstate == RIdle) && w_ar_hs && (RD_LAT == 1)) ||
                     ((r_rstate == RWait) && (r_rcnt == 32'd1));

  // Write side: a channel not yet captured still has its payload on the bus
  logic              w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit, w_w_ok;
  logic [ADDR_W-1:0] w_cm_addr;
  logic [DATA_W-1:0] w_cm_data;
  logic [STRB_W-1:0] w_cm_strb;
  assign w_aw_hs   = SRAM_awvalid & r_awready;
  assign w_w_hs    = SRAM_wvalid & r_wready;
  assign w_aw_have = w_aw_hs | ~r_awready;
  assign w_w_have  = w_w_hs | ~r_wready;
  assign w_cm_addr = r_awready ? SRAM_awaddr : r_waddr;
  assign w_cm_data = r_wready ? SRAM_wdata : r_wdata;
  assign w_cm_strb = r_wready ? SRAM_wstrb : r_wstrb;
  assign w_commit  = ((r_wstate == WIdle) && w_aw_have && w_w_have && (WR_LAT == 1)) ||
                     ((r_wstate == WWait) && (r_wcnt == 32'd1));

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic              w_r_ok;
  logic [DATA_W-1:0] w_rd_word;
  assign w_w_ok    = f_in_range(w_cm_addr);
  assign w_r_ok    = f_in_range(w_rs_addr);
  assign w_rd_word = w_r_ok ? r_mem[f_idx(w_rs_addr)] : '0;

  always_ff @(posedge clk) begin
    if (w_commit && w_w_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_cm_strb[i]) r_mem[f_idx(w_cm_addr)][8*i +: 8] <= w_cm_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= RIdle;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_raddr   <= '0;
      r_rcnt    <= '0;
    end else begin
      if (w_rsample) begin
        r_rdata <= w_rd_word;
        r_rresp <= w_r_ok ? 2'b00 : 2'b10;
      end
      unique case (r_rstate)
        RIdle: if (w_ar_hs) begin
          r_raddr   <= SRAM_araddr;
          r_arready <= 1'b0;
          r_rcnt    <= RD_LAT - 1;
          if (RD_LAT == 1) begin
            r_rstate <= RResp;
            r_rvalid <= 1'b1;
          end else begin
            r_rstate <= RWait;
          end
        end
        RWait: if (r_rcnt == 32'd1) begin
          r_rstate <= RResp;
          r_rvalid <= 1'b1;
        end else begin
          r_rcnt <= r_rcnt - 32'd1;
        end
        RResp: if (SRAM_rready) begin
          r_rstate  <= RIdle;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
        default: r_rstate <= RIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= WIdle;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wcnt    <= '0;
    end else begin
      if (w_commit) r_bresp <= w_w_ok ? 2'b00 : 2'b10;
      unique case (r_wstate)
        WIdle: begin
          if (w_aw_hs) begin
            r_waddr   <= SRAM_awaddr;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= SRAM_wdata;
            r_wstrb  <= SRAM_wstrb;
            r_wready <= 1'b0;
          end
          if (w_aw_have && w_w_have) begin
            r_wcnt <= WR_LAT - 1;
            if (WR_LAT == 1) begin
              r_wstate <= WResp;
              r_bvalid <= 1'b1;
            end else begin
              r_wstate <= WWait;
            end
          end
        end
        WWait: if (r_wcnt == 32'd1) begin
          r_wstate <= WResp;
          r_bvalid <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt - 32'd1;
        end
        WResp: if (SRAM_bready) begin
          r_wstate  <= WIdle;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
        default: r_wstate <= WIdle;
      endcase
    end
  end

  assign SRAM_arready = r_arready;
  assign SRAM_rdata   = r_rdata;
  assign SRAM_rresp   = r_rresp;
  assign SRAM_rvalid  = r_rvalid;
  assign SRAM_awready = r_awready;
  assign SRAM_wready  = r_wready;
  assign SRAM_bresp   = r_bresp;
  assign SRAM_bvalid  = r_bvalid;

endmodule

// File: tb/tb_ysyx_25030093_axil_sram.sv
// Bench for ysyx_25030093_axil_sram: instance 0 uses default latencies, instance 1 uses
// RD_LAT=4, WR_LAT=3, DEPTH_LOG2=10. Directed table, hand-written corner sequences, random ops.
module tb_ysyx_25030093_axil_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr [2], rdata [2], awaddr [2], wdata [2];
  logic        arvalid [2], arready [2], rvalid [2], rready [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic [1:0]  rresp [2], bresp [2];
  logic [3:0]  wstrb [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_25030093_axil_sram u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .SRAM_araddr(araddr[0]), .SRAM_arvalid(arvalid[0]), .SRAM_arready(arready[0]),
    .SRAM_rdata(rdata[0]), .SRAM_rresp(rresp[0]), .SRAM_rvalid(rvalid[0]),
    .SRAM_rready(rready[0]), .SRAM_awaddr(awaddr[0]), .SRAM_awvalid(awvalid[0]),
    .SRAM_awready(awready[0]), .SRAM_wdata(wdata[0]), .SRAM_wstrb(wstrb[0]),
    .SRAM_wvalid(wvalid[0]), .SRAM_wready(wready[0]), .SRAM_bresp(bresp[0]),
    .SRAM_bvalid(bvalid[0]), .SRAM_bready(bready[0])
  );

  ysyx_25030093_axil_sram #(.DEPTH_LOG2(10), .RD_LAT(4), .WR_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .SRAM_araddr(araddr[1]), .SRAM_arvalid(arvalid[1]), .SRAM_arready(arready[1]),
    .SRAM_rdata(rdata[1]), .SRAM_rresp(rresp[1]), .SRAM_rvalid(rvalid[1]),
    .SRAM_rready(rready[1]), .SRAM_awaddr(awaddr[1]), .SRAM_awvalid(awvalid[1]),
    .SRAM_awready(awready[1]), .SRAM_wdata(wdata[1]), .SRAM_wstrb(wstrb[1]),
    .SRAM_wvalid(wvalid[1]), .SRAM_wready(wready[1]), .SRAM_bresp(bresp[1]),
    .SRAM_bvalid(bvalid[1]), .SRAM_bready(bready[1])
  );

  function automatic int rd_lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int wr_lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mem_bytes(input int k);
    return (k == 0) ? 32'h0004_0000 : 32'h0000_1000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no response, expected one (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_arready"}, arready[k], 1);
    chk({tag, "_awready"}, awready[k], 1);
    chk({tag, "_wready"},  wready[k], 1);
    chk({tag, "_rvalid"},  rvalid[k], 0);
    chk({tag, "_bvalid"},  bvalid[k], 0);
    chk({tag, "_rdata"},   rdata[k], 0);
    chk({tag, "_rresp"},   rresp[k], 0);
    chk({tag, "_bresp"},   bresp[k], 0);
  endtask

  // lead > 0: W is offered that many cycles before AW; lead < 0: AW goes first
  task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead,
                          output logic [1:0] resp, output int lat);
    int cyc = 0;
    bit aw_d = 0, w_d = 0, hs_aw, hs_w;
    int aw_at = (lead > 0) ? lead : 0;
    int w_at  = (lead < 0) ? -lead : 0;
    awaddr[k] = addr;
    wdata[k]  = data;
    wstrb[k]  = strb;
    while (!(aw_d && w_d)) begin
      awvalid[k] = !aw_d && (cyc >= aw_at);
      wvalid[k]  = !w_d && (cyc >= w_at);
      hs_aw = awvalid[k] && awready[k];
      hs_w  = wvalid[k] && wready[k];
      tick();
      aw_d = aw_d | hs_aw;
      w_d  = w_d | hs_w;
      if (aw_d != w_d) begin
        chk("awready_after_capture", awready[k], !aw_d);
        chk("wready_after_capture", wready[k], !w_d);
      end
      cyc++;
      if (cyc > 50) begin
        tmo("write_handshake");
        break;
      end
    end
    awvalid[k] = 0;
    wvalid[k]  = 0;
    bready[k]  = 1;
    lat = 1;
    while (!bvalid[k]) begin
      tick();
      lat++;
      if (lat > 50) begin
        tmo("bvalid_wait");
        break;
      end
    end
    resp = bresp[k];
    tick();
    bready[k] = 0;
    chk("bvalid_drop", bvalid[k], 0);
    chk("awready_back", awready[k], 1);
    chk("wready_back", wready[k], 1);
  endtask

  task automatic do_read(input int k, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc = 0;
    araddr[k]  = addr;
    arvalid[k] = 1;
    while (!arready[k]) begin
      tick();
      cyc++;
      if (cyc > 50) begin
        tmo("arready_wait");
        break;
      end
    end
    tick();
    arvalid[k] = 0;
    lat = 1;
    while (!rvalid[k]) begin
      tick();
      lat++;
      if (lat > 50) begin
        tmo("rvalid_wait");
        break;
      end
    end
    data = rdata[k];
    resp = rresp[k];
    chk("arready_in_resp", arready[k], 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rvalid_hold", rvalid[k], 1);
      chk("rdata_stable", rdata[k], data);
      chk("rresp_stable", rresp[k], resp);
      chk("arready_stall", arready[k], 0);
    end
    rready[k] = 1;
    tick();
    rready[k] = 0;
    chk("rvalid_drop", rvalid[k], 0);
    chk("arready_back", arready[k], 1);
  endtask

  typedef struct {
    bit          wr;
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          hold;
    logic [1:0]  eresp;
    logic [31:0] erdata;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_wr(int k, logic [31:0] a, logic [31:0] d, logic [3:0] s, int lead,
                                 logic [1:0] er, string nm);
    tbl.push_back('{1'b1, k, a, d, s, lead, 0, er, 32'h0, nm});
  endfunction

  function automatic void add_rd(int k, logic [31:0] a, int hold, logic [1:0] er,
                                 logic [31:0] ed, string nm);
    tbl.push_back('{1'b0, k, a, 32'h0, 4'h0, 0, hold, er, ed, nm});
  endfunction

  logic [31:0] mdl [2][16];

  initial begin
    logic [31:0] d, a, exp_d;
    logic [1:0]  r;
    logic [3:0]  s;
    int          l, k, w, cyc;
    bit          oor;

    add_wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, "wr_full_same_cycle");
    add_rd(0, 32'h8000_0010, 2, 2'b00, 32'hDEAD_BEEF, "rd_full");
    add_wr(0, 32'h8000_0010, 32'h0000_AA00, 4'h2, 3, 2'b00, "wr_partial_w_first");
    add_rd(0, 32'h8000_0010, 0, 2'b00, 32'hDEAD_AAEF, "rd_partial");
    add_rd(0, 32'h8000_0013, 0, 2'b00, 32'hDEAD_AAEF, "rd_unaligned");
    add_wr(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, -2, 2'b00, "wr_no_strobe");
    add_rd(0, 32'h8000_0010, 0, 2'b00, 32'hDEAD_AAEF, "rd_after_no_strobe");
    add_wr(0, 32'h8000_0000, 32'h1111_1111, 4'hF, 0, 2'b00, "wr_word0");
    add_rd(0, 32'h7FFF_FFFC, 1, 2'b10, 32'h0, "rd_below_base");
    add_wr(0, 32'h8004_0000, 32'h1234_5678, 4'hF, 0, 2'b10, "wr_past_top");
    add_rd(0, 32'h8000_0000, 0, 2'b00, 32'h1111_1111, "rd_word0_unchanged");
    add_rd(0, 32'h8004_0000, 0, 2'b10, 32'h0, "rd_past_top");
    add_wr(1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 1, 2'b00, "l_wr_last_word");
    add_rd(1, 32'h8000_0FFC, 5, 2'b00, 32'hCAFE_F00D, "l_rd_lat4_hold5");
    add_wr(1, 32'h8000_0000, 32'h2222_2222, 4'hF, 0, 2'b00, "l_wr_word0");
    add_wr(1, 32'h8000_1000, 32'h3333_3333, 4'hF, -1, 2'b10, "l_wr_past_top");
    add_rd(1, 32'h8000_0000, 0, 2'b00, 32'h2222_2222, "l_rd_word0_unchanged");
    add_rd(1, 32'h7FFF_FFFC, 0, 2'b10, 32'h0, "l_rd_below_base");
    add_wr(1, 32'h8000_0020, 32'h0123_4567, 4'hF, 0, 2'b00, "l_wr_full");
    add_wr(1, 32'h8000_0020, 32'hA5A5_A5A5, 4'h9, 2, 2'b00, "l_wr_strb1001");
    add_rd(1, 32'h8000_0020, 0, 2'b00, 32'hA523_45A5, "l_rd_merged");

    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; arvalid[i] = 0; rready[i] = 0; awaddr[i] = '0; awvalid[i] = 0;
      wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 0; bready[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    @(negedge clk);
    rst_n = 1;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].k, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, r, l);
        chk({tbl[i].nm, "_bresp"}, r, tbl[i].eresp);
        chk({tbl[i].nm, "_lat"}, l, wr_lat(tbl[i].k));
      end else begin
        do_read(tbl[i].k, tbl[i].addr, tbl[i].hold, d, r, l);
        chk({tbl[i].nm, "_rdata"}, d, tbl[i].erdata);
        chk({tbl[i].nm, "_rresp"}, r, tbl[i].eresp);
        chk({tbl[i].nm, "_lat"}, l, rd_lat(tbl[i].k));
      end
    end

    // Same-edge read sample and write commit, latency 1 on both sides
    do_write(0, 32'h8000_0040, 32'h1, 4'hF, 0, r, l);
    araddr[0] = 32'h8000_0040; arvalid[0] = 1;
    awaddr[0] = 32'h8000_0040; wdata[0] = 32'h2; wstrb[0] = 4'hF; awvalid[0] = 1; wvalid[0] = 1;
    tick();
    arvalid[0] = 0; awvalid[0] = 0; wvalid[0] = 0;
    chk("samecyc_rvalid", rvalid[0], 1);
    chk("samecyc_rdata_old", rdata[0], 32'h1);
    chk("samecyc_bvalid", bvalid[0], 1);
    chk("samecyc_bresp", bresp[0], 0);
    rready[0] = 1; bready[0] = 1;
    tick();
    rready[0] = 0; bready[0] = 0;
    do_read(0, 32'h8000_0040, 0, d, r, l);
    chk("samecyc_next_read_new", d, 32'h2);

    // Same collision on the slow instance: AR one edge before the write capture
    do_write(1, 32'h8000_0044, 32'h5, 4'hF, 0, r, l);
    araddr[1] = 32'h8000_0044; arvalid[1] = 1;
    tick();
    arvalid[1] = 0;
    awaddr[1] = 32'h8000_0044; wdata[1] = 32'h6; wstrb[1] = 4'hF; awvalid[1] = 1; wvalid[1] = 1;
    tick();
    awvalid[1] = 0; wvalid[1] = 0;
    cyc = 0;
    while (!rvalid[1] && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!rvalid[1]) tmo("l_samecyc_rvalid");
    chk("l_samecyc_rdata_old", rdata[1], 32'h5);
    chk("l_samecyc_bvalid", bvalid[1], 1);
    rready[1] = 1; bready[1] = 1;
    tick();
    rready[1] = 0; bready[1] = 0;
    do_read(1, 32'h8000_0044, 0, d, r, l);
    chk("l_samecyc_next_read_new", d, 32'h6);

    // A stalled read response must not block the write channel
    do_write(1, 32'h8000_0048, 32'h77, 4'hF, 0, r, l);
    araddr[1] = 32'h8000_0048; arvalid[1] = 1;
    tick();
    arvalid[1] = 0;
    do_write(1, 32'h8000_004C, 32'h88, 4'hF, 1, r, l);
    chk("bp_write_bresp", r, 0);
    chk("bp_read_still_valid", rvalid[1], 1);
    chk("bp_read_rdata", rdata[1], 32'h77);
    rready[1] = 1;
    tick();
    rready[1] = 0;
    do_read(1, 32'h8000_004C, 0, d, r, l);
    chk("bp_write_landed", d, 32'h88);

    // Reset while a write sits in its latency wait
    do_write(1, 32'h8000_0100, 32'hAAAA_5555, 4'hF, 0, r, l);
    do_read(1, 32'h8000_0100, 0, d, r, l);
    awaddr[1] = 32'h8000_0100; wdata[1] = 32'h1234_5678; wstrb[1] = 4'hF;
    awvalid[1] = 1; wvalid[1] = 1;
    tick();
    awvalid[1] = 0; wvalid[1] = 0;
    chk("wait_awready_low", awready[1], 0);
    chk("wait_bvalid_low", bvalid[1], 0);
    rst_n = 0;
    #2;
    chk_reset(1, "midrst");
    chk_reset(0, "midrst0");
    repeat (3) @(negedge clk);
    rst_n = 1;
    tick();
    chk_reset(1, "postrst");
    do_read(1, 32'h8000_0100, 0, d, r, l);
    chk("postrst_word_kept", d, 32'hAAAA_5555);
    do_read(0, 32'h8000_0040, 0, d, r, l);
    chk("postrst_committed_kept", d, 32'h2);

    // Randomised traffic against a word-array model
    for (int kk = 0; kk < 2; kk++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        do_write(kk, BASE + 32'((32 + i) * 4), d, 4'hF, 0, r, l);
        mdl[kk][i] = d;
        chk("rnd_fill_bresp", r, 0);
      end
    end
    for (int n = 0; n < 60; n++) begin
      k   = $urandom_range(0, 1);
      w   = $urandom_range(0, 15);
      oor = ($urandom_range(0, 7) == 0);
      if (!oor) a = BASE + 32'((32 + w) * 4) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
      else a = BASE + mem_bytes(k) + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(k, a, d, s, $urandom_range(0, 6) - 3, r, l);
        chk("rnd_bresp", r, oor ? 2'b10 : 2'b00);
        chk("rnd_wlat", l, wr_lat(k));
        if (!oor) begin
          for (int b = 0; b < 4; b++) if (s[b]) mdl[k][w][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        do_read(k, a, $urandom_range(0, 2), d, r, l);
        exp_d = oor ? 32'h0 : mdl[k][w];
        chk("rnd_rdata", d, exp_d);
        chk("rnd_rresp", r, oor ? 2'b10 : 2'b00);
        chk("rnd_rlat", l, rd_lat(k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_25030093_axil_sram.md
Name: ysyx_25030093_axil_sram

Overview:
- Parametrised AXI4-Lite slave memory. It replaces the read-only single-channel SRAM model.
- Full five-channel interface: AR, R, AW, W, B. Read and write paths are independent FSMs.
- Programmable access latency, byte-strobed writes, and range-checked error responses.
- Sits behind the IFU/LSU bus arbiter in the NPC as the main-memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be 32 or 64. Strobe width is DATA_W/8.
- DEPTH_LOG2, 16, log2 of the internal array depth in DATA_W words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to first rvalid. Must be >=1.
- WR_LAT, 1, cycles from the later of AW/W capture to bvalid. Must be >=1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- SRAM_araddr  in  ADDR_W  read address
- SRAM_arvalid  in  1  read address valid
- SRAM_arready  out  1  read address ready
- SRAM_rdata  out  DATA_W  read data
- SRAM_rresp  out  2  read response (00 OKAY, 10 SLVERR)
- SRAM_rvalid  out  1  read data valid
- SRAM_rready  in  1  read data ready
- SRAM_awaddr  in  ADDR_W  write address
- SRAM_awvalid  in  1  write address valid
- SRAM_awready  out  1  write address ready
- SRAM_wdata  in  DATA_W  write data
- SRAM_wstrb  in  DATA_W/8  byte strobes
- SRAM_wvalid  in  1  write data valid
- SRAM_wready  out  1  write data ready
- SRAM_bresp  out  2  write response
- SRAM_bvalid  out  1  write response valid
- SRAM_bready  in  1  write response ready

Behaviour:
- Reset state:
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - Both FSMs go to IDLE.
  - Memory array contents are not reset.
- Address map:
  - Word index = (addr-BASE_ADDR)>>log2(DATA_W/8). Low address bits are ignored (unaligned accesses are treated as aligned).
  - In range means BASE_ADDR <= addr < BASE_ADDR + (2^DEPTH_LOG2)*(DATA_W/8). Anything else is out of range.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, register the address, load the counter with RD_LAT-1, and go to R_WAIT. If RD_LAT=1, go directly to R_RESP.
  - R_WAIT: arready=0. Decrement the counter. When it reaches 0, sample memory into rdata and go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rready.
  - On rvalid&rready, go to R_IDLE with arready=1 in the next cycle. No back-to-back overlap: throughput is 1 read per RD_LAT+1 cycles minimum.
  - Out-of-range read: rresp=10, rdata=0.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: AW and W are captured independently, in either order or the same cycle. awready drops after AW capture; wready drops after W capture.
  - When both are held, load the counter with WR_LAT-1 and go to W_WAIT (or go directly to the commit step if WR_LAT=1).
  - Commit at the transition into W_RESP: each byte with wstrb[i]=1 is written. wstrb=0 performs no write and still returns OKAY.
  - Out-of-range write: no write, bresp=10.
  - W_RESP: bvalid=1 until bready. Then return to W_IDLE with awready=wready=1.
- Read/write ordering:
  - A read sample and a write commit to the same word in the same cycle: the read returns the pre-write data.
  - A commit in cycle N is visible to any read sample in cycle N+1 or later.
- Backpressure: rready or bready held low stalls only the respective FSM indefinitely. The other channel keeps operating.
- Reset mid-operation: the pending transaction is dropped. An uncommitted write never reaches memory. A committed write persists.

Optional Feature:
- Macro SRAM_DPI_EN.
- Defined:
  - The internal array is removed. Reads call DPI-C paddr_read(addr) at the sample cycle.
  - Writes call DPI-C paddr_write(addr, {4'b0,wstrb}, wdata) at the commit cycle.
  - Only DATA_W=32 is supported. The range check is disabled: responses are always OKAY.
- Undefined: the internal 2^DEPTH_LOG2-word array is used, with range checking as above.

Test Plan:
- Write 0x8000_0010 data 0xDEADBEEF wstrb 1111, AW and W in the same cycle, WR_LAT=1 -> bvalid one cycle after capture, bresp=00. A later read of 0x8000_0010 returns 0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW; then a partial write of 0x0000_AA00 with wstrb 0010 to the same word -> read returns 0xDEADAAEF. awready/wready drop individually on capture.
- RD_LAT=4: AR handshake at cycle 0 -> rvalid first asserted at cycle 4. With rready held low 5 cycles, rdata is stable throughout and arready stays 0.
- Read of 0x7FFF_FFFC and write to BASE_ADDR+2^DEPTH_LOG2*4 -> rresp=10 with rdata=0, bresp=10, and the memory is unchanged.
- Same-cycle read sample and write commit to one word, old=0x1, new=0x2 -> read returns 0x1. The next read returns 0x2.
- Assert rst_n during W_WAIT -> after release, all outputs are at reset values and the word retains its old value.
